// File: rtl/tree_level_port_arbiter.sv
// tree_level_port_arbiter
// Shares BRAM port B between lookup lane 2 and a buffered update/readback
// channel. Updates sit in a small FIFO and issue only on idle lookup cycles.
// If the lane stays busy for MAX_WAIT cycles while an entry waits, lane-2
// injection is stalled upstream until that entry has issued.
module tree_level_port_arbiter #(
    parameter int NODE_WIDTH = 40,
    parameter int NODE_ADDR  = 9,
    parameter int FIFO_AW    = 2,
    parameter int MAX_WAIT   = 16,
    parameter int RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  RSTn,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic                  upd_rd,
    input  logic [NODE_ADDR-1:0]  upd_addr,
    input  logic [NODE_WIDTH-1:0] upd_data,
    output logic [FIFO_AW:0]      upd_pending,
    output logic                  rd_valid,
    output logic [NODE_WIDTH-1:0] rd_data,
    input  logic                  lk_valid2,
    input  logic [NODE_ADDR-1:0]  lk_addr2,
    output logic                  stall2,
    output logic [NODE_ADDR-1:0]  bram_addrb,
    output logic                  bram_web,
    output logic [NODE_WIDTH-1:0] bram_dinb,
    input  logic [NODE_WIDTH-1:0] bram_doutb
);

    localparam int DEPTH  = 1 << FIFO_AW;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [FIFO_AW:0]  FULL_CNT  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]  CNT_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARB   = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    logic [NODE_ADDR-1:0]  fifo_addr [DEPTH];
    logic                  fifo_rd   [DEPTH];
    logic [NODE_WIDTH-1:0] fifo_data [DEPTH];

    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [FIFO_AW:0]   cnt_next;
    logic [1:0]         state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [RD_LAT-1:0]  rd_pipe;
    logic [RD_LAT:0]    rd_shift;

    logic empty;
    logic full;
    logic push;
    logic grant;
    logic issue_rd;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign push     = upd_valid & ~full;
    assign grant    = ~empty & ~lk_valid2;
    assign issue_rd = grant & fifo_rd[rd_ptr];
    assign rd_shift = {rd_pipe, issue_rd};

    assign upd_ready   = ~full;
    assign upd_pending = count;

    // Occupancy after this edge's push/pop.
    always_comb begin
        cnt_next = count;
        if (push && !grant)
            cnt_next = count + CNT_ONE;
        else if (grant && !push)
            cnt_next = count - CNT_ONE;
    end

    // Port B mux: head entry on idle lane cycles, lookup address otherwise.
    always_comb begin
        bram_addrb = lk_addr2;
        bram_web   = 1'b0;
        bram_dinb  = '0;
        if (grant) begin
            bram_addrb = fifo_addr[rd_ptr];
            bram_web   = ~fifo_rd[rd_ptr];
            bram_dinb  = fifo_data[rd_ptr];
        end
    end

    // FIFO storage, written on accepted pushes.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= upd_addr;
            fifo_rd[wr_ptr]   <= upd_rd;
            fifo_data[wr_ptr] <= upd_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (grant)
                rd_ptr <= rd_ptr + PTR_ONE;
            count <= cnt_next;
        end
    end

    // Starvation FSM: counts busy cycles for the head entry, stalls the lane at MAX_WAIT.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            stall2   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (push)
                        state <= ST_ARB;
                end
                ST_ARB: begin
                    if (grant) begin
                        wait_cnt <= '0;
                        state    <= (cnt_next == '0) ? ST_IDLE : ST_ARB;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state  <= ST_STALL;
                        stall2 <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_ONE;
                    end
                end
                ST_STALL: begin
                    if (grant) begin
                        stall2   <= 1'b0;
                        wait_cnt <= '0;
                        state    <= (cnt_next == '0) ? ST_IDLE : ST_ARB;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    wait_cnt <= '0;
                    stall2   <= 1'b0;
                end
            endcase
        end
    end

    // Readback pipe: the tap RD_LAT cycles after issue captures bram_doutb.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            rd_pipe  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_pipe  <= rd_shift[RD_LAT-1:0];
            rd_valid <= rd_shift[RD_LAT];
            if (rd_shift[RD_LAT])
                rd_data <= bram_doutb;
        end
    end

endmodule

// File: tb/tb_tree_level_port_arbiter.sv
// tb_tree_level_port_arbiter
// Directed table, hand-written corner sequences, and a randomized run against
// a queue-based reference model. A behavioural 2-cycle BRAM drives bram_doutb.
module tb_tree_level_port_arbiter;

    localparam int NW    = 40;
    localparam int NA    = 9;
    localparam int DEPTH = 4;
    localparam int MAXW  = 16;

    logic          clk;
    logic          RSTn;
    logic          upd_valid;
    logic          upd_ready;
    logic          upd_rd;
    logic [NA-1:0] upd_addr;
    logic [NW-1:0] upd_data;
    logic [2:0]    upd_pending;
    logic          rd_valid;
    logic [NW-1:0] rd_data;
    logic          lk_valid2;
    logic [NA-1:0] lk_addr2;
    logic          stall2;
    logic [NA-1:0] bram_addrb;
    logic          bram_web;
    logic [NW-1:0] bram_dinb;
    logic [NW-1:0] bram_doutb;

    int n_cmp = 0;
    int n_err = 0;

    tree_level_port_arbiter #(
        .NODE_WIDTH(NW), .NODE_ADDR(NA), .FIFO_AW(2), .MAX_WAIT(MAXW), .RD_LAT(2)
    ) dut (
        .clk(clk), .RSTn(RSTn),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_rd(upd_rd),
        .upd_addr(upd_addr), .upd_data(upd_data), .upd_pending(upd_pending),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .lk_valid2(lk_valid2), .lk_addr2(lk_addr2), .stall2(stall2),
        .bram_addrb(bram_addrb), .bram_web(bram_web), .bram_dinb(bram_dinb),
        .bram_doutb(bram_doutb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural BRAM port B with two-cycle registered read.
    logic [NW-1:0] env_mem [int];
    logic [NW-1:0] env_q1 = '0;
    initial bram_doutb = '0;
    always @(posedge clk) begin
        env_q1     <= env_mem.exists(int'(bram_addrb)) ? env_mem[int'(bram_addrb)] : '0;
        bram_doutb <= env_q1;
        if (bram_web)
            env_mem[int'(bram_addrb)] = bram_dinb;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic uv, input logic ur, input logic [NA-1:0] ua,
                         input logic [NW-1:0] ud, input logic lk, input logic [NA-1:0] la);
        upd_valid = uv; upd_rd = ur; upd_addr = ua; upd_data = ud;
        lk_valid2 = lk; lk_addr2 = la;
    endtask

    task automatic do_reset(input string tag);
        RSTn = 1'b0;
        drive(0, 0, '0, '0, 0, 9'h0AB);
        @(negedge clk);
        @(negedge clk);
        #1;
        check({tag, " rst stall2"}, 64'(stall2), 0);
        check({tag, " rst rd_valid"}, 64'(rd_valid), 0);
        check({tag, " rst pending"}, 64'(upd_pending), 0);
        check({tag, " rst ready"}, 64'(upd_ready), 1);
        check({tag, " rst web"}, 64'(bram_web), 0);
        check({tag, " rst addrb"}, 64'(bram_addrb), 64'h0AB);
        RSTn = 1'b1;
    endtask

    typedef struct {
        logic          uv;
        logic          ur;
        logic [NA-1:0] ua;
        logic [NW-1:0] ud;
        logic          lk;
        logic [NA-1:0] la;
        logic [NA-1:0] e_addr;
        logic          e_web;
        logic [NW-1:0] e_din;
        logic [2:0]    e_pend;
        logic          e_ready;
        logic          e_stall;
        logic          e_rdv;
        logic [NW-1:0] e_rdd;
    } vec_t;

    // Reference model state.
    typedef struct { logic rd; logic [NA-1:0] a; logic [NW-1:0] d; } ent_t;
    typedef struct { int due; logic [NW-1:0] d; } rsp_t;
    ent_t          mq[$];
    rsp_t          rq[$];
    logic [NW-1:0] ref_mem [int];
    int            busy;
    bit            stall_m;
    logic [NW-1:0] last_rd;

    task automatic model_compare(input int n);
        bit            g;
        logic [NA-1:0] e_addr;
        logic          e_web;
        logic [NW-1:0] e_din;
        logic          e_rdv;
        bit            push_ok;
        ent_t          head;
        g      = (mq.size() != 0) && !lk_valid2;
        e_addr = lk_addr2;
        e_web  = 1'b0;
        e_din  = '0;
        if (g) begin
            e_addr = mq[0].a;
            e_web  = !mq[0].rd;
            e_din  = mq[0].d;
        end
        e_rdv = 1'b0;
        if (rq.size() != 0 && rq[0].due == n) begin
            e_rdv   = 1'b1;
            last_rd = rq[0].d;
            void'(rq.pop_front());
        end
        check($sformatf("rnd%0d addrb", n), 64'(bram_addrb), 64'(e_addr));
        check($sformatf("rnd%0d web", n), 64'(bram_web), 64'(e_web));
        check($sformatf("rnd%0d dinb", n), 64'(bram_dinb), 64'(e_din));
        check($sformatf("rnd%0d pending", n), 64'(upd_pending), 64'(mq.size()));
        check($sformatf("rnd%0d ready", n), 64'(upd_ready), 64'(mq.size() < DEPTH));
        check($sformatf("rnd%0d stall2", n), 64'(stall2), 64'(stall_m));
        check($sformatf("rnd%0d rd_valid", n), 64'(rd_valid), 64'(e_rdv));
        check($sformatf("rnd%0d rd_data", n), 64'(rd_data), 64'(last_rd));
        push_ok = upd_valid && (mq.size() < DEPTH);
        if (g) begin
            head = mq.pop_front();
            if (head.rd)
                rq.push_back('{n + 3, ref_mem.exists(int'(head.a)) ? ref_mem[int'(head.a)] : '0});
            else
                ref_mem[int'(head.a)] = head.d;
            busy    = 0;
            stall_m = 0;
        end else if (mq.size() != 0 && lk_valid2 && !stall_m) begin
            busy++;
            if (busy == MAXW)
                stall_m = 1;
        end
        if (push_ok)
            mq.push_back('{upd_rd, upd_addr, upd_data});
    endtask

    localparam logic [NW-1:0] D1 = 40'h12_3456_789A;
    localparam logic [NW-1:0] D5 = 40'hFE_DCBA_9876;

    initial begin
        vec_t          tbl [10];
        int            pct;
        logic [63:0]   r64;
        int            k;

        // Phase 1: directed table (idle, write, readback).
        tbl[0] = '{0, 0, 9'h000, '0, 0, 9'h1AA, 9'h1AA, 0, '0, 3'd0, 1, 0, 0, '0};
        tbl[1] = '{1, 0, 9'h005, D1, 0, 9'h033, 9'h033, 0, '0, 3'd0, 1, 0, 0, '0};
        tbl[2] = '{0, 0, 9'h000, '0, 0, 9'h044, 9'h005, 1, D1, 3'd1, 1, 0, 0, '0};
        tbl[3] = '{0, 0, 9'h000, '0, 0, 9'h055, 9'h055, 0, '0, 3'd0, 1, 0, 0, '0};
        tbl[4] = '{1, 1, 9'h005, '0, 0, 9'h066, 9'h066, 0, '0, 3'd0, 1, 0, 0, '0};
        tbl[5] = '{0, 0, 9'h000, '0, 0, 9'h077, 9'h005, 0, '0, 3'd1, 1, 0, 0, '0};
        tbl[6] = '{0, 0, 9'h000, '0, 1, 9'h088, 9'h088, 0, '0, 3'd0, 1, 0, 0, '0};
        tbl[7] = '{0, 0, 9'h000, '0, 0, 9'h099, 9'h099, 0, '0, 3'd0, 1, 0, 0, '0};
        tbl[8] = '{0, 0, 9'h000, '0, 1, 9'h0AA, 9'h0AA, 0, '0, 3'd0, 1, 0, 1, D1};
        tbl[9] = '{0, 0, 9'h000, '0, 0, 9'h0BB, 9'h0BB, 0, '0, 3'd0, 1, 0, 0, D1};

        do_reset("tbl");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(tbl[i].uv, tbl[i].ur, tbl[i].ua, tbl[i].ud, tbl[i].lk, tbl[i].la);
            #1;
            check($sformatf("row%0d addrb", i), 64'(bram_addrb), 64'(tbl[i].e_addr));
            check($sformatf("row%0d web", i), 64'(bram_web), 64'(tbl[i].e_web));
            check($sformatf("row%0d dinb", i), 64'(bram_dinb), 64'(tbl[i].e_din));
            check($sformatf("row%0d pending", i), 64'(upd_pending), 64'(tbl[i].e_pend));
            check($sformatf("row%0d ready", i), 64'(upd_ready), 64'(tbl[i].e_ready));
            check($sformatf("row%0d stall2", i), 64'(stall2), 64'(tbl[i].e_stall));
            check($sformatf("row%0d rd_valid", i), 64'(rd_valid), 64'(tbl[i].e_rdv));
            check($sformatf("row%0d rd_data", i), 64'(rd_data), 64'(tbl[i].e_rdd));
        end

        // Phase 2a: fill FIFO under a busy lane, full refuses push even with a pop.
        do_reset("full");
        k = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            drive(1, 0, 9'(9'h010 + k), 40'hA0_0000_0000 + 40'(k), 1, 9'h1F0);
            #1;
            check($sformatf("full c%0d pending", c), 64'(upd_pending), 64'((c < 4) ? c : 4));
            check($sformatf("full c%0d ready", c), 64'(upd_ready), 64'(c < 4));
            if (c < 4) k++;
        end
        @(negedge clk);
        drive(1, 0, 9'h014, 40'hA0_0000_0004, 0, 9'h1F0);
        #1;
        check("full pop web", 64'(bram_web), 1);
        check("full pop addrb", 64'(bram_addrb), 64'h010);
        check("full pop dinb", 64'(bram_dinb), 64'hA0_0000_0000);
        check("full pop ready", 64'(upd_ready), 0);
        check("full pop pending", 64'(upd_pending), 4);
        @(negedge clk);
        drive(1, 0, 9'h014, 40'hA0_0000_0004, 1, 9'h1F0);
        #1;
        check("full refill pending", 64'(upd_pending), 3);
        check("full refill ready", 64'(upd_ready), 1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(0, 0, '0, '0, 0, 9'h1F0);
            #1;
            check($sformatf("drain%0d addrb", c), 64'(bram_addrb), 64'(9'h011 + c));
            check($sformatf("drain%0d web", c), 64'(bram_web), 1);
            check($sformatf("drain%0d pending", c), 64'(upd_pending), 64'(4 - c));
        end
        @(negedge clk);
        #1;
        check("drain end pending", 64'(upd_pending), 0);
        check("drain end web", 64'(bram_web), 0);

        // Phase 2b: starvation stall after MAX_WAIT busy cycles, late lookup in stall.
        do_reset("stall");
        @(negedge clk);
        drive(1, 0, 9'h077, D5, 1, 9'h100);
        for (int c = 1; c <= MAXW; c++) begin
            @(negedge clk);
            drive(0, 0, '0, '0, 1, 9'(9'h100 + c));
            #1;
            check($sformatf("stall busy%0d stall2", c), 64'(stall2), 0);
            check($sformatf("stall busy%0d web", c), 64'(bram_web), 0);
        end
        @(negedge clk);
        drive(0, 0, '0, '0, 1, 9'h1EE);
        #1;
        check("stall late stall2", 64'(stall2), 1);
        check("stall late addrb", 64'(bram_addrb), 64'h1EE);
        check("stall late web", 64'(bram_web), 0);
        @(negedge clk);
        drive(0, 0, '0, '0, 0, 9'h1EE);
        #1;
        check("stall issue stall2", 64'(stall2), 1);
        check("stall issue web", 64'(bram_web), 1);
        check("stall issue addrb", 64'(bram_addrb), 64'h077);
        check("stall issue dinb", 64'(bram_dinb), 64'(D5));
        @(negedge clk);
        drive(0, 0, '0, '0, 1, 9'h1EE);
        #1;
        check("stall after stall2", 64'(stall2), 0);
        check("stall after pending", 64'(upd_pending), 0);

        // Phase 2c: async reset while a read is in flight discards the response.
        do_reset("abort");
        @(negedge clk);
        drive(1, 1, 9'h005, '0, 0, 9'h000);
        @(negedge clk);
        drive(0, 0, '0, '0, 0, 9'h000);
        #1;
        check("abort issue addrb", 64'(bram_addrb), 64'h005);
        check("abort issue web", 64'(bram_web), 0);
        @(negedge clk);
        RSTn = 1'b0;
        #1;
        check("abort rst rd_valid", 64'(rd_valid), 0);
        check("abort rst rd_data", 64'(rd_data), 0);
        check("abort rst pending", 64'(upd_pending), 0);
        check("abort rst ready", 64'(upd_ready), 1);
        check("abort rst stall2", 64'(stall2), 0);
        check("abort rst web", 64'(bram_web), 0);
        @(negedge clk);
        RSTn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("abort post%0d rd_valid", c), 64'(rd_valid), 0);
            check($sformatf("abort post%0d pending", c), 64'(upd_pending), 0);
        end

        // Phase 3: randomized traffic against the reference model.
        do_reset("rnd");
        mq.delete();
        rq.delete();
        busy    = 0;
        stall_m = 0;
        last_rd = '0;
        pct     = 50;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (n % 64 == 0) begin
                case ($urandom_range(0, 2))
                    0:       pct = 15;
                    1:       pct = 60;
                    default: pct = 98;
                endcase
            end
            r64 = {$urandom, $urandom};
            lk_valid2 = ($urandom_range(0, 99) < pct);
            if (stall_m && ($urandom_range(0, 3) != 0))
                lk_valid2 = 1'b0;
            lk_addr2  = 9'($urandom);
            upd_valid = ($urandom_range(0, 99) < 45);
            upd_rd    = 1'($urandom_range(0, 1));
            upd_addr  = 9'(9'h100 + $urandom_range(0, 7));
            upd_data  = r64[NW-1:0];
            #1;
            model_compare(n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
